ritc_tx_datapath: RTL and testbench
===================================

Name: ritc_tx_datapath

Overview:
- Transmit-side counterpart of the RITC 4:1 deserializing receive datapath, for one 12-bit channel.
- Runs in the per-channel parallel-clock domain. Accepts sample-major 48-bit words (4 samples × 12 bits), or generates training patterns, and reorders them into bit-major 4-bit nibbles for twelve 4:1 output serializers.
- Provides a per-lane bit-slip injector so the receiver's bitslip alignment can be exercised in loopback.

Parameters:
- NBITS, 12, lanes (bits per sample).
- NSAMP, 4, samples per parallel word (serialization ratio).
- TRAIN_NIBBLE, 4'b0011, nibble driven on every lane in training mode.
- UFLOW_W, 16, underflow counter width.

Ports:
- PARALLEL_CLK  in  1  parallel (divided) clock, one word per cycle.
- RST  in  1  asynchronous, active-high reset.
- MODE  in  2  00 data, 01 training, 10 ramp, 11 zero; treated as quasi-static.
- IN_DATA  in  48  sample s, bit b at [12*s+b]; s=0 oldest.
- IN_VALID  in  1  word valid.
- IN_READY  out  1  buffer can accept a word.
- SLIP_REQ  in  1  single-cycle pulse; delays all lanes by one bit-time.
- SLIP_OFFSET  out  2  current slip offset, 0..3.
- SER_Q  out  48  lane b nibble at [4*b+3:4*b]; nibble bit 0 is transmitted first.
- UFLOW_CNT  out  UFLOW_W  data-mode underflow count, saturating.
- CLR_UFLOW  in  1  synchronous clear of UFLOW_CNT.

Behaviour:
- Reset (async assert, sync release internally via 2-flop release):
  - SER_Q=0, IN_READY=0 until release, SLIP_OFFSET=0, UFLOW_CNT=0.
  - Buffer empty; ramp counter=0; previous-nibble registers=0.
- Input buffer: 2-entry FIFO.
  - IN_READY = not full.
  - A write occurs when IN_VALID && IN_READY.
  - Simultaneous push and pop on a full FIFO is allowed only when IN_READY was 1.
- Word source, selected once per cycle:
  - Data mode: pop one word if non-empty. If empty, source is all-zero and UFLOW_CNT increments, saturating at all-ones.
  - Training mode: every lane nibble = TRAIN_NIBBLE. FIFO is not popped; IN_READY still reflects FIFO state.
  - Ramp mode: samples = R, R+1, R+2, R+3 (12-bit, modulo 4096); R advances by 4 each cycle; R wraps 4092→0.
  - Zero mode: all zeros.
  - Non-data modes never increment UFLOW_CNT.
- Reorder: nibble[b][k] = sample k bit b, for b=0..11 and k=0..3.
- Slip stage:
  - Per lane, window W = {cur_nibble, prev_nibble} (8 bits).
  - Output nibble = W[offset+3 : offset] with offset = 4 - SLIP_OFFSET, and offset 4 used when SLIP_OFFSET=0. Net effect: each increment delays the stream by one bit.
  - SLIP_REQ increments SLIP_OFFSET modulo 4.
  - Wrap 3→0 yields a net 3-bit advance. This is accepted, because the receiver sees it as a rotation.
  - A new offset applies to the word registered on the cycle after the SLIP_REQ cycle.
  - SLIP_REQ during reset is ignored.
- Latency:
  - IN_DATA accepted at cycle t appears on SER_Q at t+2 when the FIFO was empty and SLIP_OFFSET=0.
  - A pattern source selected at cycle t appears at t+2.
  - A MODE change takes effect on a whole-word boundary. There are no partial words.
- CLR_UFLOW has priority over increment in the same cycle.
- Reset mid-stream: FIFO contents discarded; the first post-reset word follows the latency rules above.

Decomposition:
- Shared package ritc_pkg:
  - Mode encodings RITC_MODE_DATA/TRAIN/RAMP/ZERO.
  - Constants NBITS=12, NSAMP=4.
  - Reorder index function (sample-major ↔ bit-major), shared with the receive datapath's unscrambler.
- One natural sub-module: ritc_tx_slip_lane, a single-lane 8-bit window mux with prev-nibble register. Instantiate 12×; the offset is driven from the top.

Test Plan:
- Reset: assert RST mid-stream → SER_Q=0, SLIP_OFFSET=0, UFLOW_CNT=0 immediately (async). After release, IN_READY=1 within 3 cycles.
- Data reorder: push IN_DATA with samples 0x001, 0x002, 0x004, 0x800 → at t+2, lane 0 nibble=4'b0001, lane 1=4'b0010, lane 2=4'b0100, lane 11=4'b1000; all other lanes=0.
- Backpressure/underflow:
  - Hold IN_VALID=1 with no pops blocked → IN_READY stays 1.
  - Drop IN_VALID for 5 cycles in data mode → UFLOW_CNT=5 and SER_Q=0 for those words.
  - Pulse CLR_UFLOW together with an underflow → UFLOW_CNT=0.
- Ramp: MODE=10 for 1025 cycles → ramp word sequence increments by 4 and wraps from samples 4092..4095 back to 0..3; lane decode of SER_Q reconstructs the ramp.
- Slip: MODE=01, TRAIN_NIBBLE=0011. Pulse SLIP_REQ once → lane nibble becomes 0110 on the next word, SLIP_OFFSET=1. Three more pulses → 1100, 1001, then 0011 with SLIP_OFFSET=0.
- Mode switch: change data→training mid-stream with 2 words buffered → no partial word; training nibble appears 2 cycles after the change; buffered words remain for return to data mode.

Source files
------------

// File: rtl/ritc_pkg.sv
// Shared RITC definitions: mode encodings, word geometry and the
// sample-major <-> bit-major reorder used by both tx and rx datapaths.
package ritc_pkg;

   localparam int NBITS  = 12;
   localparam int NSAMP  = 4;
   localparam int WORD_W = NBITS * NSAMP;

   localparam logic [3:0] RITC_TRAIN_NIBBLE = 4'b0011;

   typedef enum logic [1:0] {
      RITC_MODE_DATA  = 2'b00,
      RITC_MODE_TRAIN = 2'b01,
      RITC_MODE_RAMP  = 2'b10,
      RITC_MODE_ZERO  = 2'b11
   } ritc_mode_t;

   // Sample-major word (sample k, bit b at [NBITS*k+b]) to bit-major
   // word (lane b nibble bit k at [NSAMP*b+k]).
   function automatic logic [WORD_W-1:0] ritc_sample_to_bit(input logic [WORD_W-1:0] w);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int b = 0; b < NBITS; b++) begin
         for (int k = 0; k < NSAMP; k++) begin
            r[NSAMP*b+k] = w[NBITS*k+b];
         end
      end
      return r;
   endfunction

   // Inverse of ritc_sample_to_bit, used by the receive-side unscrambler.
   function automatic logic [WORD_W-1:0] ritc_bit_to_sample(input logic [WORD_W-1:0] w);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int b = 0; b < NBITS; b++) begin
         for (int k = 0; k < NSAMP; k++) begin
            r[NBITS*k+b] = w[NSAMP*b+k];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ritc_tx_datapath_if.sv
// Word input handshake of the RITC transmit datapath.
interface ritc_tx_datapath_if
   import ritc_pkg::*;
   ();

   logic [WORD_W-1:0] IN_DATA;
   logic              IN_VALID;
   logic              IN_READY;

   modport master (output IN_DATA, output IN_VALID, input IN_READY);
   modport slave  (input IN_DATA, input IN_VALID, output IN_READY);

endinterface

// File: rtl/ritc_tx_slip_lane.sv
// One serializer lane: holds the previous nibble and selects a 4-bit
// slice of {current, previous} so the lane can be delayed by 0..3 bits.
module ritc_tx_slip_lane (
   input  logic       PARALLEL_CLK,
   input  logic       RST,
   input  logic [3:0] CUR_NIBBLE,
   input  logic [1:0] SLIP_OFFSET,
   output logic [3:0] Q
);

   logic [3:0] prev_nibble;
   logic [7:0] window;
   logic [3:0] slipped;

   assign window = {CUR_NIBBLE, prev_nibble};

   // Each slip step moves the slice one bit toward the previous nibble,
   // so the first transmitted bit comes from the tail of the older word.
   always_comb begin
      slipped = window[7:4];
      case (SLIP_OFFSET)
         2'd0: slipped = window[7:4];
         2'd1: slipped = window[6:3];
         2'd2: slipped = window[5:2];
         2'd3: slipped = window[4:1];
      endcase
   end

   // Register the slipped nibble for the serializer and remember this word's nibble.
   always_ff @(posedge PARALLEL_CLK or posedge RST) begin
      if (RST) begin
         prev_nibble <= 4'd0;
         Q           <= 4'd0;
      end else begin
         prev_nibble <= CUR_NIBBLE;
         Q           <= slipped;
      end
   end

endmodule

// File: rtl/ritc_tx_datapath.sv
// RITC transmit datapath for one 12-bit channel: 2-entry input buffer,
// word source select (data/training/ramp/zero), sample-to-bit reorder
// and per-lane bit-slip injection feeding twelve 4:1 serializers.
module ritc_tx_datapath
   import ritc_pkg::*;
#(
   parameter logic [3:0] TRAIN_NIBBLE = RITC_TRAIN_NIBBLE,
   parameter int         UFLOW_W      = 16
) (
   input  logic               PARALLEL_CLK,
   input  logic               RST,
   input  logic [1:0]         MODE,
   ritc_tx_datapath_if.slave  in_bus,
   input  logic               SLIP_REQ,
   output logic [1:0]         SLIP_OFFSET,
   output logic [WORD_W-1:0]  SER_Q,
   output logic [UFLOW_W-1:0] UFLOW_CNT,
   input  logic               CLR_UFLOW
);

   ritc_mode_t        mode;
   logic [1:0]        rst_pipe;
   logic              rst_int;
   logic [WORD_W-1:0] fifo_mem [0:1];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_cnt;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              bypass;
   logic              fifo_wr;
   logic              fifo_rd;
   logic              underflow;
   logic [WORD_W-1:0] src_word;
   logic [WORD_W-1:0] word_q;
   logic [WORD_W-1:0] nib_word;
   logic [NBITS-1:0]  ramp_r;

   assign mode = ritc_mode_t'(MODE);

   // Reset asserts immediately but releases two clocks after RST drops.
   always_ff @(posedge PARALLEL_CLK or posedge RST) begin
      if (RST) begin
         rst_pipe <= 2'b11;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b0};
      end
   end

   assign rst_int = rst_pipe[1];

   assign fifo_full       = (fifo_cnt == 2'd2);
   assign fifo_empty      = (fifo_cnt == 2'd0);
   assign in_bus.IN_READY = ~fifo_full & ~rst_int;
   assign push            = in_bus.IN_VALID & in_bus.IN_READY;
   assign fifo_wr         = push & ~bypass;

   // Pick this cycle's word; an empty buffer with a word arriving is cut through.
   always_comb begin
      src_word  = '0;
      fifo_rd   = 1'b0;
      bypass    = 1'b0;
      underflow = 1'b0;
      unique case (mode)
         RITC_MODE_DATA: begin
            if (!fifo_empty) begin
               src_word = fifo_mem[rd_ptr];
               fifo_rd  = 1'b1;
            end else if (push) begin
               src_word = in_bus.IN_DATA;
               bypass   = 1'b1;
            end else begin
               underflow = 1'b1;
            end
         end
         RITC_MODE_TRAIN: begin
            for (int k = 0; k < NSAMP; k++) begin
               src_word[NBITS*k +: NBITS] = {NBITS{TRAIN_NIBBLE[k]}};
            end
         end
         RITC_MODE_RAMP: begin
            for (int k = 0; k < NSAMP; k++) begin
               src_word[NBITS*k +: NBITS] = ramp_r + NBITS'(k);
            end
         end
         RITC_MODE_ZERO: begin
            src_word = '0;
         end
      endcase
   end

   // Buffer storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge PARALLEL_CLK) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr] <= in_bus.IN_DATA;
      end
   end

   // Buffer pointers and occupancy.
   always_ff @(posedge PARALLEL_CLK or posedge rst_int) begin
      if (rst_int) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (fifo_wr) begin
            wr_ptr <= ~wr_ptr;
         end
         if (fifo_rd) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_cnt <= fifo_cnt + {1'b0, fifo_wr} - {1'b0, fifo_rd};
      end
   end

   // Word register, ramp base and slip offset advance once per parallel word.
   always_ff @(posedge PARALLEL_CLK or posedge rst_int) begin
      if (rst_int) begin
         word_q      <= '0;
         ramp_r      <= '0;
         SLIP_OFFSET <= 2'd0;
      end else begin
         word_q <= src_word;
         if (mode == RITC_MODE_RAMP) begin
            ramp_r <= ramp_r + NBITS'(NSAMP);
         end
         if (SLIP_REQ) begin
            SLIP_OFFSET <= SLIP_OFFSET + 2'd1;
         end
      end
   end

   // Saturating underflow count; a clear beats a same-cycle underflow.
   always_ff @(posedge PARALLEL_CLK or posedge rst_int) begin
      if (rst_int) begin
         UFLOW_CNT <= '0;
      end else if (CLR_UFLOW) begin
         UFLOW_CNT <= '0;
      end else if (underflow && !(&UFLOW_CNT)) begin
         UFLOW_CNT <= UFLOW_CNT + 1'b1;
      end
   end

   assign nib_word = ritc_sample_to_bit(word_q);

   for (genvar b = 0; b < NBITS; b++) begin : g_lane
      ritc_tx_slip_lane u_lane (
         .PARALLEL_CLK (PARALLEL_CLK),
         .RST          (rst_int),
         .CUR_NIBBLE   (nib_word[NSAMP*b +: NSAMP]),
         .SLIP_OFFSET  (SLIP_OFFSET),
         .Q            (SER_Q[NSAMP*b +: NSAMP])
      );
   end

endmodule

// File: tb/tb_ritc_tx_datapath.sv
// Randomized bench for ritc_tx_datapath against a word/bit-stream model.
module tb_ritc_tx_datapath;

   logic        PARALLEL_CLK;
   logic        RST;
   logic [1:0]  MODE;
   logic        SLIP_REQ;
   logic [1:0]  SLIP_OFFSET;
   logic [47:0] SER_Q;
   logic [15:0] UFLOW_CNT;
   logic        CLR_UFLOW;

   int n_checks;
   int n_fails;

   ritc_tx_datapath_if bus ();

   ritc_tx_datapath dut (
      .PARALLEL_CLK (PARALLEL_CLK),
      .RST          (RST),
      .MODE         (MODE),
      .in_bus       (bus),
      .SLIP_REQ     (SLIP_REQ),
      .SLIP_OFFSET  (SLIP_OFFSET),
      .SER_Q        (SER_Q),
      .UFLOW_CNT    (UFLOW_CNT),
      .CLR_UFLOW    (CLR_UFLOW)
   );

   initial PARALLEL_CLK = 1'b0;
   always #5 PARALLEL_CLK = ~PARALLEL_CLK;

   // Model state: buffered words, last two source words, output, slip, counters.
   logic [47:0] m_q[$];
   logic [47:0] m_cur;
   logic [47:0] m_prv;
   logic [47:0] m_ser;
   logic [1:0]  m_off;
   logic [15:0] m_uflow;
   logic [11:0] m_ramp;
   int          m_rel;

   task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Lane b bit j of the output is the channel bit stream delayed by s bits.
   function automatic logic [47:0] expectSer(input logic [47:0] cur, input logic [47:0] prv,
                                             input logic [1:0] s);
      logic [47:0] r;
      int p;
      r = '0;
      for (int b = 0; b < 12; b++) begin
         for (int j = 0; j < 4; j++) begin
            p = j - int'(s);
            if (p >= 0) r[4*b+j] = cur[12*p+b];
            else        r[4*b+j] = prv[12*(4+p)+b];
         end
      end
      return r;
   endfunction

   task automatic modelClear();
      m_q.delete();
      m_cur   = '0;
      m_prv   = '0;
      m_ser   = '0;
      m_off   = 2'd0;
      m_uflow = '0;
      m_ramp  = '0;
   endtask

   task automatic modelEdge(input logic rst, input logic [1:0] mode, input logic valid,
                            input logic [47:0] data, input logic slip, input logic clr);
      logic [47:0] s;
      logic        und;
      if (rst || m_rel < 2) begin
         modelClear();
         if (!rst) m_rel++;
      end else begin
         s   = '0;
         und = 1'b0;
         if (valid && m_q.size() < 2) m_q.push_back(data);
         case (mode)
            2'b00: if (m_q.size() > 0) s = m_q.pop_front(); else und = 1'b1;
            2'b01: for (int k = 0; k < 4; k++) s[12*k +: 12] = {12{k < 2}};
            2'b10: begin
               for (int k = 0; k < 4; k++) s[12*k +: 12] = 12'((int'(m_ramp) + k) % 4096);
               m_ramp = 12'((int'(m_ramp) + 4) % 4096);
            end
            default: s = '0;
         endcase
         m_ser = expectSer(m_cur, m_prv, m_off);
         m_prv = m_cur;
         m_cur = s;
         m_off = 2'((int'(m_off) + int'(slip)) % 4);
         if (clr) m_uflow = '0;
         else if (und && m_uflow != 16'hFFFF) m_uflow = m_uflow + 16'd1;
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then check after the next rise.
   task automatic applyStimulus(input logic rst, input logic [1:0] mode, input logic valid,
                                input logic [47:0] data, input logic slip, input logic clr);
      RST          = rst;
      MODE         = mode;
      bus.IN_VALID = valid;
      bus.IN_DATA  = data;
      SLIP_REQ     = slip;
      CLR_UFLOW    = clr;
      #1;
      if (rst) begin
         m_rel = 0;
         modelClear();
         checkOutput("async_ser_q", SER_Q, 48'd0);
         checkOutput("async_slip_offset", {46'd0, SLIP_OFFSET}, 48'd0);
         checkOutput("async_uflow_cnt", {32'd0, UFLOW_CNT}, 48'd0);
         checkOutput("async_in_ready", {47'd0, bus.IN_READY}, 48'd0);
      end
      @(posedge PARALLEL_CLK);
      modelEdge(rst, mode, valid, data, slip, clr);
      @(negedge PARALLEL_CLK);
      checkOutput("ser_q", SER_Q, m_ser);
      checkOutput("slip_offset", {46'd0, SLIP_OFFSET}, {46'd0, m_off});
      checkOutput("uflow_cnt", {32'd0, UFLOW_CNT}, {32'd0, m_uflow});
      checkOutput("in_ready", {47'd0, bus.IN_READY},
                  {47'd0, (!rst && m_rel >= 2 && m_q.size() < 2)});
   endtask

   function automatic logic [47:0] randWord();
      return {16'($urandom), 32'($urandom)};
   endfunction

   logic [3:0] slip_exp [4];

   initial begin
      n_checks     = 0;
      n_fails      = 0;
      m_rel        = 0;
      RST          = 1'b1;
      MODE         = 2'b00;
      bus.IN_VALID = 1'b0;
      bus.IN_DATA  = '0;
      SLIP_REQ     = 1'b0;
      CLR_UFLOW    = 1'b0;
      modelClear();
      @(negedge PARALLEL_CLK);

      $display("[TB] reset and release");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0);

      $display("[TB] directed reorder");
      applyStimulus(1'b0, 2'b00, 1'b1, {12'h800, 12'h004, 12'h002, 12'h001}, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("reorder_const", SER_Q, 48'h8000_0000_0421);

      $display("[TB] underflow and clear");
      applyStimulus(1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("uflow_five", {32'd0, UFLOW_CNT}, 48'd5);
      applyStimulus(1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b1);
      checkOutput("uflow_clr_prio", {32'd0, UFLOW_CNT}, 48'd0);

      $display("[TB] streaming data");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'b00, 1'b1, randWord(), 1'b0, 1'b0);
      for (int i = 0; i < 200; i++)
         applyStimulus(1'b0, 2'b00, ($urandom_range(0, 9) < 7), randWord(),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));

      $display("[TB] training slip sequence");
      applyStimulus(1'b1, 2'b01, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b01, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("train_nibble", {44'd0, SER_Q[3:0]}, {44'd0, 4'b0011});
      slip_exp[0] = 4'b0110;
      slip_exp[1] = 4'b1100;
      slip_exp[2] = 4'b1001;
      slip_exp[3] = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 2'b01, 1'b0, '0, 1'b1, 1'b0);
         applyStimulus(1'b0, 2'b01, 1'b0, '0, 1'b0, 1'b0);
         checkOutput("slip_nibble", {44'd0, SER_Q[3:0]}, {44'd0, slip_exp[i]});
         checkOutput("slip_offset_step", {46'd0, SLIP_OFFSET}, 48'((i + 1) % 4));
      end

      $display("[TB] mode switch with buffered words");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 1'b1, randWord(), 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b1, randWord(), 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b1, randWord(), 1'b0, 1'b0);
      checkOutput("train_after_switch", SER_Q, 48'h3333_3333_3333);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b01, 1'b1, randWord(), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0);

      $display("[TB] ramp");
      for (int i = 0; i < 1030; i++) applyStimulus(1'b0, 2'b10, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b11, 1'b1, randWord(), 1'b0, 1'b0);

      $display("[TB] random modes");
      for (int blk = 0; blk < 50; blk++) begin
         logic [1:0] md;
         md = 2'($urandom_range(0, 3));
         for (int i = 0; i < 8; i++)
            applyStimulus(($urandom_range(0, 99) == 0), md, ($urandom_range(0, 9) < 6),
                          randWord(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
